// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA engine and CPU/DMA bus arbiter in front of an asynchronous memory.
// Optional OAM_DMA_READBACK_EN makes the DMA register readable by the CPU.
module oam_dma_ctrl #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [ADDR_WIDTH-1:0] OAM_BASE     = 16'hFE00,
    parameter int                    XFER_LEN     = 160
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_wr_en,
    input  logic                  cpu_rd_en,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  dma_active
);
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;
    state_t                state, state_nxt;
    logic [7:0]            src_hi, idx, src_fold;
    logic [DATA_WIDTH-1:0] data_buf;
    logic                  dma_wr, dma_rd, last;
    assign dma_wr   = cpu_wr_en && cpu_addr == DMA_REG_ADDR;
    assign dma_rd   = cpu_rd_en && cpu_addr == DMA_REG_ADDR;
    assign last     = idx == 8'(XFER_LEN - 1);
    // Pages 0xE0-0xFF are echo RAM; fold them onto 0xC0-0xDF.
    assign src_fold = cpu_wdata[7:5] == 3'b111 ? cpu_wdata[7:0] - 8'h20 : cpu_wdata[7:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_hi   <= '0;
            idx      <= '0;
            data_buf <= '0;
        end else begin
            state <= state_nxt;
            if (dma_wr) begin
                src_hi <= src_fold;
                idx    <= '0;
            end else if (state == WRITE && !last) begin
                idx <= idx + 8'd1;
            end
            if (state == READ) data_buf <= mem_rdata;
        end
    end
    always_comb begin
        state_nxt = dma_wr ? START :
                    state == START ? READ :
                    state == READ ? WRITE :
                    state == WRITE && !last ? READ : IDLE;
    end
    always_comb begin
        dma_active = state != IDLE;
        mem_addr   = state == IDLE ? cpu_addr :
                     state == WRITE ? OAM_BASE + ADDR_WIDTH'(idx) : ADDR_WIDTH'({src_hi, idx});
        mem_wdata  = state == WRITE ? data_buf : cpu_wdata;
        // A restart during a non-final byte abandons that byte; the final byte always lands.
        mem_wr_en  = state == IDLE ? cpu_wr_en && !dma_wr : state == WRITE && (last || !dma_wr);
        mem_rd_en  = state == IDLE ? cpu_rd_en && !dma_rd : state == READ;
`ifdef OAM_DMA_READBACK_EN
        cpu_rdata  = dma_rd ? DATA_WIDTH'(src_hi) : dma_active ? '1 : mem_rdata;
`else
        cpu_rdata  = dma_rd || dma_active ? '1 : mem_rdata;
`endif
    end
endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

OAM DMA engine and bus arbiter sitting directly upstream of the asynchronous `memory` array. It owns the single memory address/data/enable interface, passing CPU accesses straight through while idle and, after a CPU write to the DMA register, copying 160 bytes from `{src_hi, 8'h00}` to `OAM_BASE`. While a transfer runs, the CPU is locked off the bus.

## Interface
- `ADDR_WIDTH`, 16: address bus width.
- `DATA_WIDTH`, 8: data bus width.
- `DMA_REG_ADDR`, 16'hFF46: CPU address of the DMA start register.
- `OAM_BASE`, 16'hFE00: destination base address.
- `XFER_LEN`, 160: bytes per transfer.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_addr` in ADDR_WIDTH: CPU address.
- `cpu_wdata` in DATA_WIDTH: CPU write data.
- `cpu_wr_en` in 1: CPU write strobe.
- `cpu_rd_en` in 1: CPU read strobe.
- `cpu_rdata` out DATA_WIDTH: read data returned to the CPU.
- `mem_addr` out ADDR_WIDTH: to memory `addr_bus`.
- `mem_wdata` out DATA_WIDTH: to memory `data_in`.
- `mem_wr_en` out 1: to memory `wr_en`.
- `mem_rd_en` out 1: to memory `rd_en`.
- `mem_rdata` in DATA_WIDTH: from memory `data_out`.
- `dma_active` out 1: transfer in progress.

## Operation
- **States:** IDLE, START, READ, WRITE. Registers: `src_hi` (8b), `idx` (8b, 0..XFER_LEN-1), `buf` (DATA_WIDTH).
- **DMA register write:** a CPU write with `cpu_addr==DMA_REG_ADDR` loads `src_hi` with `cpu_wdata`, mapped as follows:
  - 0xE0–0xFF is stored minus 0x20 (echo-RAM fold).
  - Other values are stored as-is.
  - This write is never forwarded (`mem_wr_en`=0).
  - It is accepted in any state.
  - It forces `idx`=0 and next state START.
- **IDLE:** combinational passthrough: `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `mem_wr_en`=`cpu_wr_en` (except the DMA register write), `mem_rd_en`=`cpu_rd_en`, `cpu_rdata`=`mem_rdata`.
- **START:** one dead cycle. Bus is idle (`mem_rd_en`=`mem_wr_en`=0). Next state is READ.
- **READ:** `mem_addr`={`src_hi`,`idx`}, `mem_rd_en`=1. `buf` captures `mem_rdata` at the cycle-ending edge. Next state is WRITE.
- **WRITE:** `mem_addr`=`OAM_BASE`+`idx`, `mem_wdata`=`buf`, `mem_wr_en`=1.
  - If `idx`==XFER_LEN-1: next state IDLE.
  - Otherwise: `idx`++ and next state READ.
- **CPU lockout:** in START/READ/WRITE, CPU writes (other than to the DMA register) are dropped and CPU reads return all-ones (0xFF).
- **Status output:** `dma_active`=1 in START/READ/WRITE, else 0 (combinational from state).
- **Reset:** asserting `rst_n` low at any time, including mid-transfer, immediately sets state IDLE, `idx`=0, `src_hi`=0x00, `buf`=0x00, `dma_active`=0. Mem outputs revert to passthrough. Partial OAM contents are left as written.
- **Simultaneous events:** a DMA register write on the same edge as the final WRITE lets the final byte complete, then restarts (START).
- **Mid-transfer DMA register write:** during READ/WRITE it aborts the current byte; no write is issued for it.

## Timing
- A DMA register write sampled at edge E0 puts the block in START for cycle 1. Byte n is read in cycle 2+2n and written in cycle 3+2n.
- Total active time is 1+2·XFER_LEN = 321 cycles. `dma_active` falls after the edge ending cycle 321.
- Memory read is asynchronous: `mem_rdata` must settle within the READ cycle. No wait states.
- Passthrough adds zero cycles of latency (purely combinational).

## Configuration
- **`OAM_DMA_READBACK_EN` defined:** a CPU read of `DMA_REG_ADDR` returns the stored `src_hi`, in any state, without asserting `mem_rd_en`.
- **`OAM_DMA_READBACK_EN` undefined:** a read of `DMA_REG_ADDR` returns 0xFF and is not forwarded to memory.

## Test plan
- **Basic copy:** preload 0xC000–0xC09F with i^0x5A, write 0xC0 to 0xFF46 → `dma_active` high for exactly 321 cycles; 0xFE00–0xFE9F equal i^0x5A.
- **Lockout:** during a transfer, CPU read 0x8000 → 0xFF; CPU write 0x33 to 0xC100 → 0xC100 unchanged after completion.
- **Echo fold and register passthrough:** write 0xE1 → source is 0xC100. Write to 0xFF46 never asserts `mem_wr_en` for 0xFF46. With `OAM_DMA_READBACK_EN`, reading 0xFF46 returns 0xC1; without it, returns 0xFF.
- **Restart:** at byte 50, write 0xD0 → `idx` restarts at 0, `dma_active` stays high 321 more cycles, OAM holds the 0xD0xx data.
- **Reset mid-transfer:** drop `rst_n` at byte 80 → `dma_active`=0 immediately; 0xFE00–0xFE4F copied, 0xFE51+ untouched; CPU passthrough read works next cycle.
